// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer handshake bundle: imem req/ack, hazard/redirect inputs,
// PC-control outputs and debug state.
interface fetch_sequencer_if;
   logic       imem_ack;
   logic       stall;
   logic       jmp;
   logic       branch_taken;
   logic       jmp_r;
   logic       imem_req;
   logic       pc_enable;
   logic       sel_jmp;
   logic       sel_branch;
   logic       sel_jmp_r;
   logic       flush;
   logic       if_valid;
   logic       fetch_timeout;
   logic [1:0] state;

   modport master (
      input  imem_ack, stall, jmp, branch_taken, jmp_r,
      output imem_req, pc_enable, sel_jmp, sel_branch, sel_jmp_r,
      output flush, if_valid, fetch_timeout, state
   );

   modport slave (
      output imem_ack, stall, jmp, branch_taken, jmp_r,
      input  imem_req, pc_enable, sel_jmp, sel_branch, sel_jmp_r,
      input  flush, if_valid, fetch_timeout, state
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: startup hold, imem req/ack sequencing,
// redirect capture with priority select, stall handling and timeout trap.
module fetch_sequencer #(
   parameter int unsigned STARTUP_CYCLES = 2,
   parameter int unsigned MAX_WAIT       = 15
) (
   input  logic clk,
   input  logic reset,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {
      HOLD = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      ERR  = 2'b11
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] boot_q, boot_d;
   logic [7:0] wait_q, wait_d;
   // Pending redirect kinds: {jmp_r, branch, jmp}
   logic [2:0] pend_q, pend_d;
   logic [2:0] redir;
   logic       active, done, complete;
   logic       req, pc_en, s_jmp, s_br, s_jr, fl, iv, tmo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= HOLD;
         boot_q  <= 4'(STARTUP_CYCLES);
         wait_q  <= 8'd0;
         pend_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         boot_q  <= boot_d;
         wait_q  <= wait_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      boot_d   = boot_q;
      wait_d   = wait_q;
      pend_d   = pend_q;
      req      = 1'b0;
      pc_en    = 1'b0;
      s_jmp    = 1'b0;
      s_br     = 1'b0;
      s_jr     = 1'b0;
      fl       = 1'b0;
      iv       = 1'b0;
      tmo      = 1'b0;
      active   = (state_q == REQ) || (state_q == WAIT);
      redir    = pend_q | {bus.jmp_r, bus.branch_taken, bus.jmp};
      done     = active && bus.imem_ack;
      complete = done && !bus.stall;

      unique case (state_q)
         HOLD: begin
            boot_d = boot_q - 4'd1;
            if (boot_q <= 4'd1) state_d = REQ;
         end
         REQ: begin
            req = 1'b1;
            if (!bus.imem_ack) begin
               state_d = WAIT;
               wait_d  = 8'd1;
            end
         end
         WAIT: begin
            req = 1'b1;
            if (bus.imem_ack)                  state_d = REQ;
            else if (wait_q == 8'(MAX_WAIT))   state_d = ERR;
            else                               wait_d  = wait_q + 8'd1;
         end
         ERR: tmo = 1'b1;
      endcase

      // A stalled completion keeps (and keeps accumulating) the redirect
      if (active) pend_d = complete ? 3'd0 : redir;

      if (complete) begin
         pc_en = 1'b1;
         if (redir == 3'd0) begin
            iv = 1'b1;
         end else begin
            fl     = 1'b1;
            s_jr   = redir[2];
            s_br   = !redir[2] && redir[1];
            s_jmp  = !redir[2] && !redir[1];
         end
      end
   end

   assign bus.imem_req      = req;
   assign bus.pc_enable     = pc_en;
   assign bus.sel_jmp       = s_jmp;
   assign bus.sel_branch    = s_br;
   assign bus.sel_jmp_r     = s_jr;
   assign bus.flush         = fl;
   assign bus.if_valid      = iv;
   assign bus.fetch_timeout = tmo;
   assign bus.state         = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random segmented stimulus against a
// request-age reference model; a negedge monitor pops and compares.
module tb_fetch_sequencer;
   localparam int S  = 2;
   localparam int MW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   fetch_sequencer_if bus();

   fetch_sequencer #(
      .STARTUP_CYCLES(S),
      .MAX_WAIT(MW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [9:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: edges since reset release, age of the outstanding request,
   // timeout trap, and the set of redirect kinds not yet consumed.
   int         boot = 0;
   int         age = 0;
   bit         err = 1'b0;
   logic [2:0] pend = 3'd0;

   initial begin
      bus.imem_ack     = 1'b0;
      bus.stall        = 1'b0;
      bus.jmp          = 1'b0;
      bus.branch_taken = 1'b0;
      bus.jmp_r        = 1'b0;
   end

   // Bit order: req, pc_en, sel_jmp, sel_branch, sel_jmp_r,
   // flush, if_valid, timeout, state[1:0]
   task automatic step(input logic r, input logic a, input logic s,
                       input logic j, input logic b, input logic jr);
      logic [9:0] e;
      logic [2:0] kinds;
      reset            = r;
      bus.imem_ack     = a;
      bus.stall        = s;
      bus.jmp          = j;
      bus.branch_taken = b;
      bus.jmp_r        = jr;
      e     = '0;
      kinds = pend | {jr, b, j};
      if (r) begin
         boot = 0;
         age  = 0;
         err  = 1'b0;
         pend = 3'd0;
      end else if (err) begin
         e[2]   = 1'b1;
         e[1:0] = 2'b11;
      end else if (boot < S) begin
         boot++;
      end else begin
         e[9]   = 1'b1;
         e[1:0] = (age == 0) ? 2'b01 : 2'b10;
         if (a) begin
            age = 0;
            if (s) begin
               pend = kinds;
            end else begin
               e[8] = 1'b1;
               pend = 3'd0;
               if (kinds == 3'd0) e[3] = 1'b1;
               else begin
                  e[4] = 1'b1;
                  if (kinds[2])      e[5] = 1'b1;
                  else if (kinds[1]) e[6] = 1'b1;
                  else               e[7] = 1'b1;
               end
            end
         end else begin
            pend = kinds;
            if (age == MW) err = 1'b1;
            else           age++;
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      logic [9:0] e;
      logic [9:0] a;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.imem_req, bus.pc_enable, bus.sel_jmp, bus.sel_branch,
                 bus.sel_jmp_r, bus.flush, bus.if_valid, bus.fetch_timeout,
                 bus.state};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL outputs cyc=%0d actual=%b required=%b",
                        cyc, a, e);
            end
         end
      end
   end

   initial begin : driver
      logic a, s, j, b, jr, r;
      int mode;
      @(posedge clk);
      #1;
      for (int seg = 0; seg < 24; seg++) begin
         mode = seg % 6;
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
         for (int c = 0; c < 60; c++) begin
            r  = 1'b0;
            s  = ($urandom_range(0, 5) == 0);
            j  = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 7) == 0);
            jr = ($urandom_range(0, 7) == 0);
            unique case (mode)
               0: begin a = 1'b1; s = 1'b0; j = 0; b = 0; jr = 0; end
               1: a = (age == 3);
               2: a = (c > 20) ? 1'(($urandom_range(0, 1))) : 1'b0;
               3: begin
                  a = 1'($urandom_range(0, 1));
                  r = ($urandom_range(0, 39) == 0);
               end
               4: begin
                  a = 1'($urandom_range(0, 1));
                  if ($urandom_range(0, 3) == 0) begin
                     j = 1; b = 1; jr = 1;
                  end
               end
               default: begin
                  a = (age == 2);
                  s = ($urandom_range(0, 2) == 0);
               end
            endcase
            step(r, a, s, j, b, jr);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
